step_controller: RTL and testbench

Clock-enable generator that sits directly upstream of the single-cycle datapath's PC register. It turns a raw board push-button and run switch into a clean one-cycle `step_en` pulse, so the datapath advances exactly one instruction per press or auto-runs at a slow, visible rate. It stops issuing steps when the datapath reports `halt`. It also keeps a step counter for the seven-segment display path.

---
 rtl/step_ctrl_pkg.sv | 19 +
 rtl/step_controller_debouncer.sv | 53 +++++
 rtl/step_controller.sv | 134 +++++++++++++
 tb/tb_step_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_ctrl_pkg.sv
// Shared types and default constants for the step controller.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_RUN_DIV         = 25_000_000;
    localparam int unsigned DEF_CNT_W           = 16;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step_controller_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer.
module debouncer
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic        RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned     CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any cycle that agrees with the accepted value restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            db_q    <= RST_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/step_controller.sv
// Clock-enable generator for the datapath PC: single-step on key press,
// periodic auto-run, sticky halt, and a running step counter.
module step_controller
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned RUN_DIV         = DEF_RUN_DIV,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_step,
    input  logic             sw_run,
    input  logic             halt,
    output logic             step_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned   TW        = cnt_width(RUN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(RUN_DIV - 1);

    logic             key_db;
    logic             run_on;
    logic             key_prev_q;
    logic             press;
    state_e           state_q;
    state_e           state_d;
    logic [TW-1:0]    tick_q;
    logic [TW-1:0]    tick_d;
    logic             step_en_q;
    logic             step_en_d;
    logic             running_q;
    logic             running_d;
    logic             halted_q;
    logic             halted_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RST_VAL         (1'b1)
    ) u_key_db (
        .clk   (clk),
        .rst_n (reset),
        .din   (key_step),
        .dout  (key_db)
    );

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RST_VAL         (1'b0)
    ) u_run_db (
        .clk   (clk),
        .rst_n (reset),
        .din   (sw_run),
        .dout  (run_on)
    );

    // Falling edge of the debounced, active-low key.
    assign press = key_prev_q & ~key_db;

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        step_en_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = HALTED;
                end else begin
                    if (press) begin
                        step_en_d = 1'b1;
                    end
                    if (run_on) begin
                        state_d = RUN;
                        tick_d  = '0;
                    end
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                    tick_d  = '0;
                end else if (!run_on) begin
                    state_d = IDLE;
                    tick_d  = '0;
                end else if (tick_q == TICK_LAST) begin
                    step_en_d = 1'b1;
                    tick_d    = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase
        running_d = (state_d == RUN);
        halted_d  = (state_d == HALTED);
        count_d   = count_q + CNT_W'(step_en_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_prev_q <= 1'b1;
            state_q    <= IDLE;
            tick_q     <= '0;
            step_en_q  <= 1'b0;
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            key_prev_q <= key_db;
            state_q    <= state_d;
            tick_q     <= tick_d;
            step_en_q  <= step_en_d;
            running_q  <= running_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    assign step_en    = step_en_q;
    assign running    = running_q;
    assign halted     = halted_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_step_controller.sv
// Scoreboard bench for step_controller: expected pulses (cycle, count) are
// derived from the latency rules and matched by independent monitors.
module tb_step_controller;

    localparam int unsigned DEB  = 4;
    localparam int unsigned RD   = 5;
    localparam int unsigned CW   = 16;
    localparam int unsigned CWW  = 4;
    localparam int unsigned LAT  = 2 + DEB;

    typedef struct {
        int unsigned cyc;
        int unsigned cnt;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           key = 1'b1;
    logic           sw = 1'b0;
    logic           halt = 1'b0;
    logic           step_en;
    logic           running;
    logic           halted;
    logic [CW-1:0]  step_count;

    logic           key_w = 1'b1;
    logic           sw_w = 1'b0;
    logic           halt_w = 1'b0;
    logic           step_en_w;
    logic           running_w;
    logic           halted_w;
    logic [CWW-1:0] step_count_w;

    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned errors = 0;
    int unsigned mcnt = 0;
    int unsigned e, r_edge, f_edge, n, off, hold, k, h_edge;
    exp_t        q[$];
    exp_t        qw[$];

    step_controller #(.DEBOUNCE_CYCLES(DEB), .RUN_DIV(RD), .CNT_W(CW)) dut (
        .clk(clk), .reset(rst_n), .key_step(key), .sw_run(sw), .halt(halt),
        .step_en(step_en), .running(running), .halted(halted), .step_count(step_count)
    );

    step_controller #(.DEBOUNCE_CYCLES(DEB), .RUN_DIV(RD), .CNT_W(CWW)) dut_w (
        .clk(clk), .reset(rst_n), .key_step(key_w), .sw_run(sw_w), .halt(halt_w),
        .step_en(step_en_w), .running(running_w), .halted(halted_w), .step_count(step_count_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_edge(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void push(input int unsigned c);
        exp_t x;
        mcnt  = mcnt + 1;
        x.cyc = c;
        x.cnt = mcnt % (1 << CW);
        q.push_back(x);
    endfunction

    // Main-instance monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t x;
        if (rst_n) begin
            if (step_en) begin
                if (q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_step_en: pulse at cycle %0d, none pending", cyc);
                end else begin
                    x = q.pop_front();
                    check("pulse_cycle", cyc, x.cyc);
                    check("pulse_count", 32'(step_count), x.cnt);
                end
            end else if (q.size() != 0 && cyc >= q[0].cyc) begin
                x = q.pop_front();
                check("missing_pulse_at", 32'(0), x.cyc);
            end
        end
    end

    // Narrow-counter instance monitor, used for the wrap boundary.
    always @(negedge clk) begin
        exp_t x;
        if (rst_n) begin
            if (step_en_w) begin
                if (qw.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_step_en_w: pulse at cycle %0d, none pending", cyc);
                end else begin
                    x = qw.pop_front();
                    check("wrap_pulse_cycle", cyc, x.cyc);
                    check("wrap_pulse_count", 32'(step_count_w), x.cnt);
                end
            end else if (qw.size() != 0 && cyc >= qw[0].cyc) begin
                x = qw.pop_front();
                check("wrap_missing_pulse_at", 32'(0), x.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t x;
        #1;
        check("rst_step_en", 32'(step_en), 0);
        check("rst_running", 32'(running), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_step_count", 32'(step_count), 0);
        wait_edge(2);
        rst_n = 1'b1;

        // Clean press landing at edge 10, held 20 cycles.
        wait_edge(9);
        key = 1'b0;
        push(10 + LAT);
        wait_edge(29);
        key = 1'b1;
        wait_edge(30);
        check("clean_press_count", 32'(step_count), 1);

        // Bouncy press: 2 low, 1 high, 2 low.
        wait_edge(39);
        key = 1'b0;
        wait_edge(41);
        key = 1'b1;
        wait_edge(42);
        key = 1'b0;
        wait_edge(44);
        key = 1'b1;
        wait_edge(60);
        check("bounce_count", 32'(step_count), mcnt);

        // Presses of random length, including the exact debounce boundary.
        for (int i = 0; i < 8; i++) begin
            hold = (i == 0) ? DEB - 1 : (i == 1) ? DEB : $urandom_range(1, 2 * DEB + 2);
            e = cyc + 1;
            key = 1'b0;
            if (hold >= DEB) push(e + LAT);
            wait_edge(cyc + hold);
            key = 1'b1;
            wait_edge(cyc + DEB + $urandom_range(3, 7));
        end
        check("press_loop_count", 32'(step_count), mcnt);

        // Auto-run bursts; the first lowers the switch so its IDLE transition
        // coincides with a terminal count.
        for (int r = 0; r < 3; r++) begin
            n   = (r == 0) ? 4 : $urandom_range(2, 5);
            off = (r == 0) ? RD : $urandom_range(1, RD);
            e = cyc + 1;
            sw = 1'b1;
            r_edge = e + LAT;
            for (int j = 1; j <= int'(n); j++) push(r_edge + j * RD);
            wait_edge(r_edge - 1);
            check("run_before_entry", 32'(running), 0);
            wait_edge(r_edge);
            check("run_after_entry", 32'(running), 1);
            f_edge = r_edge + n * RD - LAT + off;
            wait_edge(f_edge - 1);
            sw = 1'b0;
            wait_edge(f_edge + LAT - 1);
            check("run_before_exit", 32'(running), 1);
            wait_edge(f_edge + LAT);
            check("run_after_exit", 32'(running), 0);
            check("run_count", 32'(step_count), mcnt);
            wait_edge(cyc + 2 * RD);
        end

        // Narrow counter: 17 auto-run steps cross the 4-bit wrap.
        e = cyc + 1;
        sw_w = 1'b1;
        r_edge = e + LAT;
        for (int j = 1; j <= 17; j++) begin
            x.cyc = r_edge + j * RD;
            x.cnt = j % (1 << CWW);
            qw.push_back(x);
        end
        f_edge = r_edge + 17 * RD - LAT + 1;
        wait_edge(f_edge - 1);
        sw_w = 1'b0;
        wait_edge(f_edge + LAT + 2);
        check("wrap_final_count", 32'(step_count_w), 1);

        // Reset asserted mid-RUN after three pulses.
        e = cyc + 1;
        sw = 1'b1;
        r_edge = e + LAT;
        for (int j = 1; j <= 3; j++) push(r_edge + j * RD);
        wait_edge(r_edge + 3 * RD + 1);
        #3;
        rst_n = 1'b0;
        sw = 1'b0;
        key = 1'b0;
        #1;
        check("midrun_rst_step_en", 32'(step_en), 0);
        check("midrun_rst_running", 32'(running), 0);
        check("midrun_rst_halted", 32'(halted), 0);
        check("midrun_rst_count", 32'(step_count), 0);
        mcnt = 0;
        @(posedge clk);
        #1;
        wait_edge(cyc + 2);
        rst_n = 1'b1;
        e = cyc + 1;
        push(e + LAT);
        wait_edge(e + LAT + 3);
        key = 1'b1;
        wait_edge(cyc + DEB + 4);
        check("post_rst_count", 32'(step_count), mcnt);

        // Halt on a terminal-count edge, then try to restart it.
        k = $urandom_range(1, 3);
        e = cyc + 1;
        sw = 1'b1;
        r_edge = e + LAT;
        h_edge = r_edge + k * RD;
        for (int j = 1; j < int'(k); j++) push(r_edge + j * RD);
        wait_edge(h_edge - 1);
        halt = 1'b1;
        wait_edge(h_edge);
        check("halt_halted", 32'(halted), 1);
        check("halt_running", 32'(running), 0);
        wait_edge(h_edge + 1);
        halt = 1'b0;
        key = 1'b0;
        wait_edge(cyc + 12);
        key = 1'b1;
        wait_edge(cyc + 12);
        sw = 1'b0;
        wait_edge(cyc + 12);
        check("halt_sticky", 32'(halted), 1);
        check("halt_no_run", 32'(running), 0);
        check("halt_count", 32'(step_count), mcnt);

        wait_edge(cyc + 5);
        check("pending_main", q.size(), 0);
        check("pending_wrap", qw.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
